// File: rtl/decode_issue_pkg.sv
// ---------------------------------------------------------------------------
// decode_issue_pkg
//   Shared constants for the fetch and decode/issue stages: opcodes, the
//   load-forward select code and the EX pipeline register layout.
//   No ports (package).
// ---------------------------------------------------------------------------
package decode_issue_pkg;

    // Opcodes shared with the fetch-stage hazard decode.
    localparam logic [5:0] SDW    = 6'h2B;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] LDW    = 6'h23;
    localparam logic [5:0] JUMP   = 6'h02;
    localparam logic [5:0] _STALL = 6'h3F;

    // Forward select: take load data from the memory stage.
    localparam logic [2:0] FWD_LD2 = 3'd2;

    // Register index width (32 architectural registers).
    localparam int REG_AW = 5;

    // EX pipeline register contents.
    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
    } ex_reg_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
//   Register file with two asynchronous read ports and one synchronous write
//   port. Register 0 always reads as zero and ignores writes. Synchronous
//   active-high reset clears every register; writes during reset are dropped.
//
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     we, waddr, wdata    write port (sampled on rising edge)
//     raddr_a / rdata_a   read port A (combinational)
//     raddr_b / rdata_b   read port B (combinational)
// ---------------------------------------------------------------------------
module regfile_2r1w
    import decode_issue_pkg::*;
#(
    parameter int RF_DEPTH = 32,
    parameter int AW       = REG_AW,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem [RF_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    // r0 is forced to zero on the read side as well, so the array entry
    // never matters even if it were somehow disturbed.
    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/decode_issue.sv
// ---------------------------------------------------------------------------
// decode_issue
//   Decode / operand-issue stage. Decodes the fetched instruction, reads the
//   register file, applies load forwarding (and optionally same-cycle write
//   bypass) and registers the result into the EX pipeline register with one
//   cycle of latency. Bubbles ({_STALL, 26'b0}) issue as invalid EX entries
//   and are counted in a saturating counter.
//
//   There is no valid/ready handshake: the EX register updates on every
//   rising edge; stalls arrive as bubble instructions from fetch.
//
//   Configuration macro:
//     DECODE_WB_BYPASS_EN  when defined, a writeback to a source register in
//                          the same cycle is bypassed into the operand.
//
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     instr_in, pc_in               instruction and its PC from fetch
//     ld_rs_in, ld_rt_in            load-forward selects (FWD_LD2 = forward)
//     mem_fwd_data                  load data leaving the memory stage
//     wb_en, wb_addr, wb_data       register-file writeback port
//     ex_valid .. ex_pc             EX pipeline register
//     bubble_cnt                    saturating count of issued bubbles
// ---------------------------------------------------------------------------
module decode_issue
    import decode_issue_pkg::*;
#(
    parameter int RF_DEPTH = 32,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_in,
    input  logic [31:0]      pc_in,
    input  logic [2:0]       ld_rs_in,
    input  logic [2:0]       ld_rt_in,
    input  logic [31:0]      mem_fwd_data,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    output logic             ex_valid,
    output logic [5:0]       ex_opcode,
    output logic [4:0]       ex_rd,
    output logic [31:0]      ex_a,
    output logic [31:0]      ex_b,
    output logic [31:0]      ex_imm,
    output logic [31:0]      ex_pc,
    output logic [CNT_W-1:0] bubble_cnt
);

    // ------------------------------------------------------------------
    // Field decode (identical to the fetch-stage hazard decode)
    // ------------------------------------------------------------------
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        is_bubble;

    always_comb begin
        opcode    = instr_in[31:26];
        rs        = instr_in[20:16];
        rt        = instr_in[15:11];
        rd        = instr_in[25:21];
        is_bubble = (opcode == _STALL);
        if (opcode == SDW || opcode == BEQ || opcode == LDW) begin
            rt = instr_in[25:21];
        end
        if (opcode == SDW || opcode == BEQ || opcode == JUMP) begin
            rd = '0;
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [31:0] rf_a;
    logic [31:0] rf_b;

    regfile_2r1w #(
        .RF_DEPTH (RF_DEPTH),
        .AW       (REG_AW),
        .DW       (32)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs),
        .rdata_a (rf_a),
        .raddr_b (rt),
        .rdata_b (rf_b)
    );

    // ------------------------------------------------------------------
    // Operand select. Later assignments override earlier ones, so the
    // statement order encodes priority: r0 > load forward > wb bypass > RF.
    // ------------------------------------------------------------------
    logic [31:0] op_a;
    logic [31:0] op_b;

    always_comb begin
        op_a = rf_a;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && wb_addr != '0 && wb_addr == rs) begin
            op_a = wb_data;
        end
`endif
        if (ld_rs_in == FWD_LD2) begin
            op_a = mem_fwd_data;
        end
        if (rs == '0) begin
            op_a = '0;
        end
    end

    always_comb begin
        op_b = rf_b;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && wb_addr != '0 && wb_addr == rt) begin
            op_b = wb_data;
        end
`endif
        if (ld_rt_in == FWD_LD2) begin
            op_b = mem_fwd_data;
        end
        if (rt == '0) begin
            op_b = '0;
        end
    end

    // ------------------------------------------------------------------
    // EX register next value. A bubble keeps only its PC; everything else
    // is zero with the _STALL opcode.
    // ------------------------------------------------------------------
    ex_reg_t ex_d;
    ex_reg_t ex_q;

    always_comb begin
        ex_d        = '0;
        ex_d.opcode = _STALL;
        ex_d.pc     = pc_in;
        if (!is_bubble) begin
            ex_d.valid  = 1'b1;
            ex_d.opcode = opcode;
            ex_d.rd     = rd;
            ex_d.a      = op_a;
            ex_d.b      = op_b;
            ex_d.imm    = sign_ext16(instr_in[15:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            ex_q.opcode <= _STALL;
        end else begin
            ex_q <= ex_d;
        end
    end

    // ------------------------------------------------------------------
    // Saturating bubble counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (is_bubble && bubble_cnt != '1) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    assign ex_valid  = ex_q.valid;
    assign ex_opcode = ex_q.opcode;
    assign ex_rd     = ex_q.rd;
    assign ex_a      = ex_q.a;
    assign ex_b      = ex_q.b;
    assign ex_imm    = ex_q.imm;
    assign ex_pc     = ex_q.pc;

endmodule

// File: tb/tb_decode_issue.sv
module tb_decode_issue;
    import decode_issue_pkg::*;

    // A narrow counter keeps the saturation corner reachable in a few cycles.
    localparam int CW    = 4;
    localparam int EXP_W = 1 + 6 + 5 + 32 * 4 + CW;
    localparam logic [5:0] OTH = 6'h00;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [31:0]   instr_in = '0;
    logic [31:0]   pc_in = '0;
    logic [2:0]    ld_rs_in = '0;
    logic [2:0]    ld_rt_in = '0;
    logic [31:0]   mem_fwd_data = '0;
    logic          wb_en = 1'b0;
    logic [4:0]    wb_addr = '0;
    logic [31:0]   wb_data = '0;
    logic          ex_valid;
    logic [5:0]    ex_opcode;
    logic [4:0]    ex_rd;
    logic [31:0]   ex_a;
    logic [31:0]   ex_b;
    logic [31:0]   ex_imm;
    logic [31:0]   ex_pc;
    logic [CW-1:0] bubble_cnt;

    decode_issue #(.RF_DEPTH(32), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_in     (instr_in),
        .pc_in        (pc_in),
        .ld_rs_in     (ld_rs_in),
        .ld_rt_in     (ld_rt_in),
        .mem_fwd_data (mem_fwd_data),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .ex_valid     (ex_valid),
        .ex_opcode    (ex_opcode),
        .ex_rd        (ex_rd),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_imm       (ex_imm),
        .ex_pc        (ex_pc),
        .bubble_cnt   (bubble_cnt)
    );

    // ---------------- vectors ----------------
    typedef struct {
        logic          rst;
        logic [31:0]   instr;
        logic [31:0]   pc;
        logic [2:0]    ld_rs;
        logic [2:0]    ld_rt;
        logic [31:0]   fwd;
        logic          wb_en;
        logic [4:0]    wb_addr;
        logic [31:0]   wb_data;
        logic          e_valid;
        logic [5:0]    e_op;
        logic [4:0]    e_rd;
        logic [31:0]   e_a;
        logic [31:0]   e_b;
        logic [31:0]   e_imm;
        logic [CW-1:0] e_cnt;
    } vec_t;

    function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] f25,
                                        input logic [4:0] rs, input logic [15:0] imm);
        return {op, f25, rs, imm};
    endfunction

    function automatic vec_t row(
        input logic rst_v, input logic [31:0] instr, input logic [31:0] pc,
        input logic [2:0] lrs, input logic [2:0] lrt, input logic [31:0] fwd,
        input logic wen, input logic [4:0] wa, input logic [31:0] wd,
        input logic ev, input logic [5:0] eop, input logic [4:0] erd,
        input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] eimm,
        input logic [CW-1:0] ecnt);
        vec_t v;
        v.rst = rst_v; v.instr = instr; v.pc = pc; v.ld_rs = lrs; v.ld_rt = lrt;
        v.fwd = fwd; v.wb_en = wen; v.wb_addr = wa; v.wb_data = wd;
        v.e_valid = ev; v.e_op = eop; v.e_rd = erd; v.e_a = ea; v.e_b = eb;
        v.e_imm = eimm; v.e_cnt = ecnt;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        logic [EXP_W-1:0] e;
        logic [31:0]      e_pc;
        @(negedge clk);
        rst = v.rst; instr_in = v.instr; pc_in = v.pc;
        ld_rs_in = v.ld_rs; ld_rt_in = v.ld_rt; mem_fwd_data = v.fwd;
        wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data;
        e_pc = v.rst ? 32'h0 : v.pc;
        exp_q.push_back({v.e_valid, v.e_op, v.e_rd, v.e_a, v.e_b, v.e_imm, e_pc, v.e_cnt});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s queue: got empty, want entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " ex_valid"},   32'(ex_valid),   32'(e[EXP_W-1]));
            chk({tag, " ex_opcode"},  32'(ex_opcode),  32'(e[EXP_W-2 -: 6]));
            chk({tag, " ex_rd"},      32'(ex_rd),      32'(e[EXP_W-8 -: 5]));
            chk({tag, " ex_a"},       ex_a,            e[CW+127 -: 32]);
            chk({tag, " ex_b"},       ex_b,            e[CW+95 -: 32]);
            chk({tag, " ex_imm"},     ex_imm,          e[CW+63 -: 32]);
            chk({tag, " ex_pc"},      ex_pc,           e[CW+31 -: 32]);
            chk({tag, " bubble_cnt"}, 32'(bubble_cnt), 32'(e[CW-1:0]));
        end
    endtask

    // ---------------- test ----------------
    vec_t tbl[13];
    logic [31:0] same_cyc_a;
    logic [31:0] ldw_a;
    logic [31:0] bub;

    initial begin
`ifdef DECODE_WB_BYPASS_EN
        same_cyc_a = 32'hA5A5A5A5;
        ldw_a      = 32'h00000055;
`else
        same_cyc_a = 32'h00000001;
        ldw_a      = 32'hA5A5A5A5;
`endif
        bub = {_STALL, 26'b0};

        // Two reset cycles carrying a live instruction and an r3 write that must be ignored.
        tbl[0]  = row(1, ins(OTH, 5'd4, 5'd3, 16'h0001), 32'h40, 0, 0, 0, 1, 5'd3, 32'hBAD0BAD0,
                      0, _STALL, 0, 0, 0, 0, 0);
        tbl[1]  = row(1, ins(OTH, 5'd4, 5'd3, 16'h0001), 32'h44, 0, 0, 0, 1, 5'd3, 32'hBAD0BAD0,
                      0, _STALL, 0, 0, 0, 0, 0);
        // First post-reset bubble.
        tbl[2]  = row(0, bub, 32'h100, 0, 0, 0, 0, 0, 0, 0, _STALL, 0, 0, 0, 0, 1);
        // Bubble while writing r5.
        tbl[3]  = row(0, bub, 32'h104, 0, 0, 0, 1, 5'd5, 32'h00001234, 0, _STALL, 0, 0, 0, 0, 2);
        // Read r5 (written last cycle) and r3 (reset write ignored); write r7=1.
        tbl[4]  = row(0, ins(OTH, 5'd9, 5'd5, 16'h1800), 32'h108, 0, 0, 0, 1, 5'd7, 32'h1,
                      1, OTH, 5'd9, 32'h1234, 0, 32'h1800, 2);
        // Same-cycle write and read of r7.
        tbl[5]  = row(0, ins(OTH, 5'd2, 5'd7, 16'h0000), 32'h10C, 0, 0, 0, 1, 5'd7, 32'hA5A5A5A5,
                      1, OTH, 5'd2, same_cyc_a, 0, 0, 2);
        // LDW rt=r7 with load forward beating a simultaneous wb of r7.
        tbl[6]  = row(0, ins(LDW, 5'd7, 5'd7, 16'hFFFC), 32'h110, 0, FWD_LD2, 32'hDEADBEEF,
                      1, 5'd7, 32'h55, 1, LDW, 5'd7, ldw_a, 32'hDEADBEEF, 32'hFFFFFFFC, 2);
        // Bubble right after LDW; attempted write to r0.
        tbl[7]  = row(0, bub, 32'h114, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0, _STALL, 0, 0, 0, 0, 3);
        // r0 sources with forward requested still read 0.
        tbl[8]  = row(0, ins(OTH, 5'd1, 5'd0, 16'h0000), 32'h118, FWD_LD2, FWD_LD2, 32'h12345678,
                      0, 0, 0, 1, OTH, 5'd1, 0, 0, 0, 3);
        // SDW: rt from [25:21], rd forced 0, negative immediate.
        tbl[9]  = row(0, ins(SDW, 5'd7, 5'd5, 16'h8000), 32'h11C, 0, 0, 0, 0, 0, 0,
                      1, SDW, 0, 32'h1234, 32'h55, 32'hFFFF8000, 3);
        // BEQ: rt from [25:21], rd forced 0.
        tbl[10] = row(0, ins(BEQ, 5'd5, 5'd7, 16'h0010), 32'h120, 0, 0, 0, 0, 0, 0,
                      1, BEQ, 0, 32'h55, 32'h1234, 32'h10, 3);
        // JUMP: rd forced 0, rt from [15:11] (=5), operands issued.
        tbl[11] = row(0, ins(JUMP, 5'd5, 5'd7, 16'h2800), 32'h124, 0, 0, 0, 0, 0, 0,
                      1, JUMP, 0, 32'h55, 32'h1234, 32'h2800, 3);
        // Non-2 forward codes do not forward.
        tbl[12] = row(0, ins(OTH, 5'd3, 5'd9, 16'h3800), 32'h128, 3'd3, 3'd6, 32'hDEAD0000,
                      0, 0, 0, 1, OTH, 5'd3, 0, 32'h55, 32'h3800, 3);

        for (int i = 0; i < 13; i++) begin
            apply($sformatf("row%0d", i), tbl[i]);
        end

        // Mid-stream reset: in-flight EX contents and registers are discarded.
        apply("pre_rst", row(0, ins(OTH, 5'd4, 5'd5, 16'h3800), 32'h200, 0, 0, 0, 0, 0, 0,
                             1, OTH, 5'd4, 32'h1234, 32'h55, 32'h3800, 3));
        apply("mid_rst", row(1, ins(OTH, 5'd4, 5'd5, 16'h3800), 32'h204, 0, 0, 0, 1, 5'd6, 32'h77,
                             0, _STALL, 0, 0, 0, 0, 0));
        apply("post_rst", row(0, ins(OTH, 5'd4, 5'd5, 16'h3800), 32'h208, 0, 0, 0, 0, 0, 0,
                              1, OTH, 5'd4, 0, 0, 32'h3800, 0));

        // Saturation of the bubble counter, with randomised PCs.
        for (int i = 0; i < 18; i++) begin
            logic [31:0] p;
            logic [CW-1:0] c;
            p = {$urandom_range(0, 32'h3FFF), 2'b00};
            c = (i + 1 >= (1 << CW) - 1) ? {CW{1'b1}} : CW'(i + 1);
            apply($sformatf("sat%0d", i), row(0, bub, p, 0, 0, 0, 0, 0, 0, 0, _STALL, 0, 0, 0, 0, c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decode_issue.md
# decode_issue

Decode/operand-issue stage sitting directly downstream of the fetch stage in the 5-stage pipeline. Consumes the fetched instruction, PC and load-use forwarding selects (`ld_rs`/`ld_rt`). Owns the 32x32 register file and its writeback port. Registers decoded opcode, destination, operands and sign-extended immediate into the EX pipeline register, with one cycle of latency.

## Interface
- `RF_DEPTH`, 32: number of architectural registers; r0 is hardwired to zero.
- `CNT_W`, 16: width of the bubble performance counter.

- `clk` in 1: pipeline clock.
- `rst` in 1: synchronous, active-high reset.
- `instr_in` in 32: instruction from fetch. It may be a `{`_STALL, 26'b0}` bubble.
- `pc_in` in 32: PC of `instr_in`.
- `ld_rs_in` in 3: forwarding select for rs. 3'd2 means take load data from the memory stage; any other value means no forward.
- `ld_rt_in` in 3: forwarding select for rt, same encoding as `ld_rs_in`.
- `mem_fwd_data` in 32: load result currently leaving the memory stage.
- `wb_en` in 1: register-file write enable.
- `wb_addr` in 5: write address.
- `wb_data` in 32: write data.
- `ex_valid` out 1: EX register holds a real instruction.
- `ex_opcode` out 6: registered opcode.
- `ex_rd` out 5: registered destination register.
- `ex_a` out 32: registered rs operand.
- `ex_b` out 32: registered rt operand.
- `ex_imm` out 32: sign-extended `instr[15:0]`.
- `ex_pc` out 32: registered PC.
- `bubble_cnt` out CNT_W: saturating count of issued bubbles.

## Operation
- **Field decode** (matches the fetch-stage hazard decode exactly):
  - opcode = `[31:26]`.
  - rs = `[20:16]`.
  - rt = `[25:21]` for `SDW`, `BEQ` and `LDW`; otherwise `[15:11]`.
  - rd = 0 for `SDW`, `BEQ` and `JUMP`; otherwise `[25:21]`.
- **Operand select**, per operand, in priority order:
  1. `ld_*_in == 3'd2` → `mem_fwd_data`.
  2. Write bypass (see Configuration) → `wb_data`.
  3. Otherwise, register-file read.
  - A source index of 0 always yields 0, including when a forward is requested.
- **Register file writes:** a write occurs on a rising edge when `wb_en && wb_addr != 0 && !rst`. Writes to r0 are dropped.
- **Bubble** (opcode == `_STALL`):
  - `ex_valid`=0, `ex_opcode`=`_STALL`.
  - `ex_rd`, `ex_a`, `ex_b` and `ex_imm` are 0; `ex_pc` = `pc_in`.
  - `bubble_cnt` increments and saturates at all-ones.
- **JUMP:** `ex_valid`=1, `ex_rd`=0, operands are issued normally (EX ignores them).
- **Other opcodes:** `ex_valid`=1, all fields are registered from the decode.

## Timing
- **Latency:** 1 cycle. The EX register updates on every rising edge. There is no stall input, because stalls arrive as bubble instructions.
- **Register-file read:** asynchronous (combinational) and sampled into the EX register at the same edge.
- **Write vs. read:** a writeback at edge N is visible to an instruction decoded in cycle N+1 through the array. Within cycle N itself, visibility depends on the bypass macro.
- **Reset values**, applied on the first edge with `rst`=1:
  - `ex_valid`=0, `ex_opcode`=`_STALL`.
  - `ex_rd`, `ex_a`, `ex_b`, `ex_imm` and `ex_pc` are 0.
  - `bubble_cnt`=0.
  - All registers are cleared to 0.
  - A `wb_en` write in a reset cycle is ignored.
  - Reset asserted mid-stream discards the in-flight EX contents. The first instruction after reset deassertion issues one cycle later.
- **Simultaneous load-forward and writeback to the same register:** the load forward wins.
- **Simultaneous bubble and `bubble_cnt` at max:** the counter holds its value.

## Configuration
- **`DECODE_WB_BYPASS_EN` defined:** when `wb_en && wb_addr != 0 && wb_addr == src` in the same cycle, the operand takes `wb_data`. This is write-before-read behaviour.
- **`DECODE_WB_BYPASS_EN` undefined:** the operand takes the old array value, and the new value is visible from the next cycle onward.

## Structure
- **Shared constants:** opcodes (`SDW`, `BEQ`, `LDW`, `JUMP`, `_STALL`) and the forward-select code `FWD_LD2`=3'd2 belong in `def.v`, the shared include with the fetch stage. Nothing is redefined locally.
- **Sub-module `regfile_2r1w`:** two asynchronous read ports, one synchronous write port, synchronous clear on `rst`, and r0 forced to zero. The bypass and forward muxes stay in `decode_issue`.

## Test plan
- **Reset:** hold `rst` for 2 cycles, then release with a bubble input → all `ex_*`=0, `ex_opcode`=`_STALL`, `ex_valid`=0, `bubble_cnt`=1 after the first post-reset bubble.
- **Writeback then read:** wb r5=0x00001234, then issue an instruction with rs=5 the next cycle → `ex_a`=0x00001234 one cycle later.
- **Same-cycle write and read of r7:**
  - Setup: wb r7=0xA5A5A5A5 while an instruction reads r7, with old r7=0x1.
  - Required response: `ex_a`=0xA5A5A5A5 with the macro defined, 0x00000001 without.
- **Load forward priority:**
  - Setup: `ld_rt_in`=3'd2, `mem_fwd_data`=0xDEADBEEF, with a simultaneous wb to the same register of 0x55.
  - Required response: `ex_b`=0xDEADBEEF.
- **r0 handling:** wb r0=0xFFFFFFFF, then read r0 with `ld_rs_in`=2 → `ex_a`=0.
- **LDW with imm=0xFFFC, followed by a `_STALL`:**
  - Required response: `ex_imm`=0xFFFFFFFC, `ex_rd`=`instr[25:21]`, `ex_valid`=1.
  - The next cycle shows `ex_valid`=0 and `bubble_cnt` incremented by 1.
